div: RTL and testbench
======================

Name: div

Overview:
- Multicycle radix-2 restoring divider: the inverse companion of the multicycle Booth multiplier.
- Serves the pipeline's DIV/DIVU instructions and uses the same start/busy handshake, so the EX-stage stall logic treats both units identically.
- Computes a 32-bit quotient and remainder, signed or unsigned, in a fixed 33 busy cycles.

Parameters:
- WIDTH, 32, operand/result width; the count register is clog2(WIDTH)+1 bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
- start  input  1  one-cycle pulse; loads operands and begins a division.
- sign  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- a  input  WIDTH  dividend; sampled with start.
- b  input  WIDTH  divisor; sampled with start.
- q  output  WIDTH  quotient; registered.
- r  output  WIDTH  remainder; registered.
- dz  output  1  divide-by-zero flag for the last completed operation.
- busy  output  1  high while a division is in progress.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, busy=0, q=0, r=0, dz=0, count=0, internal registers=0.
  - Reset overrides start.
  - Reset in the middle of an operation aborts it. No result is written.
- States and transitions:
  - IDLE: on start, go to CALC.
  - CALC: runs WIDTH cycles, then goes to FIX.
  - FIX: one cycle, then back to IDLE.
- Start edge (cycle 0):
  - Latch |a| and |b|. The magnitude is used only when sign=1 and the MSB is set; otherwise the raw value is latched.
  - Latch neg_q = sign & (a[MSB]^b[MSB]) and neg_r = sign & a[MSB].
  - Clear the partial remainder; count=0; busy=1.
- CALC, one step per cycle:
  - Shift {rem, quo} left by 1.
  - Form trial = rem_shifted - divisor, at WIDTH+1 bits.
  - If trial is non-negative: rem=trial and the quotient LSB=1. Otherwise the quotient LSB=0.
  - Increment count.
  - After WIDTH steps, go to FIX.
- FIX:
  - q = neg_q ? -quo : quo; r = neg_r ? -rem : rem (two's complement, WIDTH bits).
  - dz = (divisor==0); busy=0; go to IDLE.
- Latency: busy is high for exactly WIDTH+1 = 33 cycles after the start edge. q, r and dz are valid on the edge where busy falls.
- Output hold: q, r and dz hold their value until the next FIX. They are not cleared by start.
- Rounding: the quotient truncates toward zero; the remainder takes the sign of the dividend; a == q*b + r always holds when b != 0.
- Divide by zero: the algorithm runs unmodified.
  - Unsigned: q=all ones, r=a.
  - Signed: r=a; q=all ones, or 1 if a is negative (negation of all ones).
  - dz=1 in every divide-by-zero case; no exception is raised.
- Signed overflow (most-negative / -1): q=0x8000_0000 (wraps), r=0, dz=0.
- Start while busy: the operation restarts with the new operands; the old result is discarded. This matches the multiplier.
- Start and busy-fall in the same cycle: start wins. The FIX result is still written that edge, and busy stays 1.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, CALC, FIX);
  - DIV_WIDTH=32;
  - DIV_CYCLES=DIV_WIDTH+1, which the hazard unit uses for stall accounting.
- No sub-module. The trial subtract and sign fix are inline combinational logic; a single module of about 150 lines.

Test Plan:
- Signed 7 / -2 -> q=0xFFFFFFFD, r=1, dz=0. busy rises 1 cycle after start, stays high 33 cycles, then falls.
- Signed -7 / 2 -> q=0xFFFFFFFD, r=0xFFFFFFFF. Unsigned 0xFFFFFFFF / 16 -> q=0x0FFFFFFF, r=0xF.
- Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0. The same operands unsigned -> q=0, r=0x80000000.
- Divide by zero:
  - unsigned 100 / 0 -> q=0xFFFFFFFF, r=100, dz=1;
  - signed -5 / 0 -> q=1, r=0xFFFFFFFB, dz=1;
  - a following 10 / 3 -> dz=0, q=3, r=1.
- Start 100 / 7; re-pulse start at cycle 10 with 9 / 4 -> busy stays high 33 cycles from the second start; final q=2, r=1.
- Start 100 / 7, then reset=0 at cycle 15 -> next edge busy=0, q=0, r=0, dz=0. A start in the same cycle as reset is ignored.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the multicycle restoring divider: widths, cycle count
// and the control-state encoding used by the divider and the hazard unit.
package div_pkg;

    localparam int DIV_WIDTH  = 32;
    localparam int DIV_CYCLES = DIV_WIDTH + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    // Control state kept together so checkers can bind to one signal.
    typedef struct packed {
        logic [1:0] state;
        logic       busy;
    } div_ctrl_t;

endpackage

// File: rtl/div.sv
// Multicycle radix-2 restoring divider, signed or unsigned, WIDTH+1 busy cycles.
// Handshake: a one-cycle start pulse loads operands; busy is high from the edge
// after start until the edge where q/r/dz are written. Start always restarts.
module div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dz,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    div_ctrl_t        ctrl;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign busy = ctrl.busy;

    always_comb begin
        abs_a   = (sign && a[WIDTH-1]) ? -a : a;
        abs_b   = (sign && b[WIDTH-1]) ? -b : b;
        // The quotient MSB shifts into the remainder LSB each step.
        rem_sh  = {rem, quo[WIDTH-1]};
        trial   = rem_sh - {1'b0, divisor};
        quo_fix = neg_q ? -quo : quo;
        rem_fix = neg_r ? -rem : rem;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl.state <= ST_IDLE;
            ctrl.busy  <= 1'b0;
            count      <= '0;
            rem        <= '0;
            quo        <= '0;
            divisor    <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            q          <= '0;
            r          <= '0;
            dz         <= 1'b0;
        end else begin
            case (ctrl.state)
                ST_CALC: begin
                    if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        ctrl.state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    q          <= quo_fix;
                    r          <= rem_fix;
                    dz         <= (divisor == '0);
                    ctrl.busy  <= 1'b0;
                    ctrl.state <= ST_IDLE;
                end
                default: begin
                    ctrl.state <= ST_IDLE;
                end
            endcase

            // A start overrides any step in flight; a FIX write above still lands.
            if (start) begin
                rem        <= '0;
                quo        <= abs_a;
                divisor    <= abs_b;
                neg_q      <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r      <= sign & a[WIDTH-1];
                count      <= '0;
                ctrl.busy  <= 1'b1;
                ctrl.state <= ST_CALC;
            end
        end
    end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for the restoring divider: directed cases from the
// arithmetic rules plus randomized operands against a plain-arithmetic model.
module tb_div;
    import div_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_r[$];
    logic [31:0] exp_dz[$];

    div dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .sign (sign),
        .a    (a),
        .b    (b),
        .q    (q),
        .r    (r),
        .dz   (dz),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: quotient truncates toward zero, remainder follows the dividend.
    function automatic void model(input logic s, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] mq, output logic [31:0] mr,
                                  output logic [31:0] mdz);
        longint sx, sy, tq, tr;
        if (y == 32'd0) begin
            mdz = 32'd1;
            mr  = x;
            mq  = (s && x[31]) ? 32'd1 : 32'hFFFF_FFFF;
        end else begin
            mdz = 32'd0;
            if (s) begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
            end else begin
                sx = longint'({32'd0, x});
                sy = longint'({32'd0, y});
            end
            tq = sx / sy;
            tr = sx % sy;
            mq = tq[31:0];
            mr = tr[31:0];
        end
    endfunction

    task automatic launch(input logic s, input logic [31:0] x, input logic [31:0] y,
                          input bit keep);
        logic [31:0] mq, mr, mdz;
        sign  = s;
        a     = x;
        b     = y;
        start = 1'b1;
        if (keep) begin
            model(s, x, y, mq, mr, mdz);
            exp_q.push_back(mq);
            exp_r.push_back(mr);
            exp_dz.push_back(mdz);
        end
        step();
        start = 1'b0;
    endtask

    task automatic check_result(input string tag);
        logic [31:0] eq, er, edz;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_queue: observed empty expected entry", tag);
        end else begin
            eq  = exp_q.pop_front();
            er  = exp_r.pop_front();
            edz = exp_dz.pop_front();
            check({tag, "_q"}, q, eq);
            check({tag, "_r"}, r, er);
            check({tag, "_dz"}, {31'd0, dz}, edz);
        end
    endtask

    // Called right after the start edge; counts busy cycles up to a bound.
    task automatic wait_done(input string tag);
        int cycles = 0;
        check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
        while (busy === 1'b1 && cycles < 100) begin
            step();
            cycles++;
        end
        check({tag, "_cycles"}, cycles, DIV_CYCLES);
        check_result(tag);
    endtask

    task automatic run(input string tag, input logic s, input logic [31:0] x,
                       input logic [31:0] y);
        launch(s, x, y, 1'b1);
        wait_done(tag);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        reset = 1'b0;
        start = 1'b1;
        sign  = 1'b0;
        a     = 32'd55;
        b     = 32'd3;
        repeat (3) step();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_q", q, 32'd0);
        check("reset_r", r, 32'd0);
        check("reset_dz", {31'd0, dz}, 32'd0);
        start = 1'b0;
        reset = 1'b1;
        step();

        run("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        run("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run("u_max_16", 1'b0, 32'hFFFF_FFFF, 32'd16);
        run("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run("u_ovf_ops", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        run("u_dz", 1'b0, 32'd100, 32'd0);
        run("s_dz", 1'b1, 32'hFFFF_FFFB, 32'd0);
        run("u_10_3", 1'b0, 32'd10, 32'd3);

        // Restart: first operation is discarded, outputs hold the old result.
        launch(1'b0, 32'd100, 32'd7, 1'b0);
        repeat (4) step();
        check("hold_q", q, 32'd3);
        check("hold_r", r, 32'd1);
        repeat (5) step();
        launch(1'b0, 32'd9, 32'd4, 1'b1);
        wait_done("restart");

        // Start coinciding with the FIX edge: result written, busy stays high.
        launch(1'b1, 32'hFFFF_FC18, 32'd10, 1'b1);
        repeat (32) step();
        check("prefix_busy", {31'd0, busy}, 32'd1);
        launch(1'b0, 32'd1234567, 32'd89, 1'b1);
        check("overlap_busy", {31'd0, busy}, 32'd1);
        check_result("overlap_first");
        wait_done("overlap_second");

        for (int i = 0; i < 20; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run($sformatf("rand%0d", i), rs, ra, rb);
        end

        // Reset mid-operation aborts; a simultaneous start is ignored.
        run("pre_abort", 1'b0, 32'd9, 32'd4);
        launch(1'b0, 32'd100, 32'd7, 1'b0);
        repeat (14) step();
        reset = 1'b0;
        start = 1'b1;
        a     = 32'd77;
        b     = 32'd5;
        step();
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_q", q, 32'd0);
        check("abort_r", r, 32'd0);
        check("abort_dz", {31'd0, dz}, 32'd0);
        reset = 1'b1;
        start = 1'b0;
        repeat (3) step();
        check("abort_idle_busy", {31'd0, busy}, 32'd0);
        check("abort_idle_q", q, 32'd0);

        run("post_abort", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
